// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: controller states, arctangent table and binary-angle constants.
// Binary angle scale: 0x4000 = +90 deg, 0x8000 = 180 deg.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] ANG_90  = 16'h4000;
    localparam logic [15:0] ANG_180 = 16'h8000;

    // Entry k is atan(2^-k) in binary-angle units; index 0 is the rightmost element.
    localparam logic [15:0][15:0] ATAN_TABLE = {
        16'd0,    16'd1,    16'd1,    16'd3,
        16'd5,    16'd10,   16'd20,   16'd41,
        16'd81,   16'd163,  16'd326,  16'd651,
        16'd1297, 16'd2555, 16'd4836, 16'd8192
    };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index -> atan(2^-i), zero latency, no flow control.
// Table values are positive, so widening to DATA_W zero-extends.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        idx,
    output logic [DATA_W-1:0] atan
);

    always_comb begin
        atan = DATA_W'(ATAN_TABLE[idx]);
    end

endmodule

// File: rtl/cordic_ctrl.sv
// Iterative CORDIC (rotation/vectoring); done pulses N_ITER+1 cycles after start is accepted, start ignored unless ready.
// Optional quadrant pre-rotation on load is enabled by defining CORDIC_QUAD_CORR_EN.
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_ITER = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    input  logic signed [DATA_W-1:0] z_in,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] x_out,
    output logic signed [DATA_W-1:0] y_out,
    output logic signed [DATA_W-1:0] z_out
);

    localparam logic [4:0]               LAST  = 5'(N_ITER);
    localparam logic signed [DATA_W-1:0] A90   = DATA_W'(ANG_90);
    localparam logic signed [DATA_W-1:0] A180  = DATA_W'(ANG_180);

    state_t                     state, state_nx;
    logic                       mode_q;
    logic [4:0]                 i_q;
    logic signed [DATA_W-1:0]   x_q, y_q, z_q;
    logic signed [DATA_W-1:0]   x_ld, y_ld, z_ld;
    logic signed [DATA_W-1:0]   x_sh, y_sh;
    logic signed [DATA_W-1:0]   x_nx, y_nx, z_nx;
    logic [DATA_W-1:0]          atan;
    logic                       d_pos;

    cordic_atan_rom #(.DATA_W(DATA_W)) u_rom (
        .idx  (i_q[3:0]),
        .atan (atan)
    );

    always_comb begin
        x_ld = x_in;
        y_ld = y_in;
        z_ld = z_in;
`ifdef CORDIC_QUAD_CORR_EN
        if (!mode) begin
            if (z_in > A90) begin
                x_ld = -y_in;
                y_ld = x_in;
                z_ld = z_in - A90;
            end else if (z_in < -A90) begin
                x_ld = y_in;
                y_ld = -x_in;
                z_ld = z_in + A90;
            end
        end else if (x_in < 0) begin
            x_ld = -x_in;
            y_ld = -y_in;
            z_ld = z_in + A180;
        end
`else
        // Unmodified load; A180 kept referenced so both builds share one declaration set.
        if (A180 == '0) begin
            z_ld = z_in;
        end
`endif
    end

    // Rotation drives z toward zero, vectoring drives y toward zero.
    always_comb begin
        d_pos = mode_q ? y_q[DATA_W-1] : ~z_q[DATA_W-1];
        x_sh  = y_q >>> i_q;
        y_sh  = x_q >>> i_q;
        x_nx  = d_pos ? (x_q - x_sh) : (x_q + x_sh);
        y_nx  = d_pos ? (y_q + y_sh) : (y_q - y_sh);
        z_nx  = d_pos ? (z_q - $signed(atan)) : (z_q + $signed(atan));
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_ITER;
            ST_ITER: if (i_q == LAST) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= 1'b0;
            i_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_q    <= x_ld;
                        y_q    <= y_ld;
                        z_q    <= z_ld;
                        mode_q <= mode;
                        i_q    <= '0;
                    end
                end
                ST_ITER: begin
                    if (i_q != LAST) begin
                        x_q <= x_nx;
                        y_q <= y_nx;
                        z_q <= z_nx;
                        i_q <= i_q + 5'd1;
                    end else begin
                        x_out <= x_q;
                        y_out <= y_q;
                        z_out <= z_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_ITER);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_cordic_ctrl.sv
// Scoreboard bench for cordic_ctrl: directed operands queue expected results, a monitor checks each done pulse.
module tb_cordic_ctrl;

    localparam int DATA_W = 16;
    localparam int N_ITER = 16;

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic                     mode;
    logic signed [DATA_W-1:0] x_in, y_in, z_in;
    logic                     ready, busy, done;
    logic signed [DATA_W-1:0] x_out, y_out, z_out;

    typedef struct {
        int x;
        int y;
        int z;
        int tx;
        int ty;
        int tz;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    cordic_ctrl #(.DATA_W(DATA_W), .N_ITER(N_ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input int act, input int expv, input int tol);
        int diff;
        checks++;
        diff = act - expv;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/-%0d (t=%0t)", name, act, expv, tol, $time);
        end
    endfunction

    // Monitor: one-hot status every cycle, scoreboard pop on every done pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        chk("status_onehot", int'(ready) + int'(busy) + int'(done), 1, 0);
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc, 0);
                chk("x_out", int'(x_out), e.x, e.tx);
                chk("y_out", int'(y_out), e.y, e.ty);
                chk("z_out", int'(z_out), e.z, e.tz);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%0b after %0d cycles, expected 1", ready, n);
        end
    endtask

    // Drives one start pulse from posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic start_op(input logic m, input int xi, input int yi, input int zi,
                            input logic expect_done, input exp_t e);
        wait_ready();
        mode  = m;
        x_in  = 16'(xi);
        y_in  = 16'(yi);
        z_in  = 16'(zi);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_done) begin
            e.cyc = cyc + N_ITER + 1;
            sb.push_back(e);
        end
    endtask

    task automatic settle();
        repeat (N_ITER + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        x_in  = '0;
        y_in  = '0;
        z_in  = '0;
        #12;
        chk("rst_ready", int'(ready), 1, 0);
        chk("rst_busy",  int'(busy),  0, 0);
        chk("rst_done",  int'(done),  0, 0);
        chk("rst_x_out", int'(x_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rotation by 0: pure CORDIC gain on x.
        e = '{x: 16384, y: 0, z: 0, tx: 8, ty: 8, tz: 32, cyc: 0};
        start_op(1'b0, 9949, 0, 0, 1'b1, e);
        settle();

        // Rotation by +45 deg.
        e = '{x: 11585, y: 11585, z: 0, tx: 8, ty: 8, tz: 32, cyc: 0};
        start_op(1'b0, 9949, 0, 16'h2000, 1'b1, e);
        settle();

        // Rotation by -45 deg.
        e = '{x: 11585, y: -11585, z: 0, tx: 8, ty: 8, tz: 32, cyc: 0};
        start_op(1'b0, 9949, 0, -8192, 1'b1, e);
        settle();

        // Vectoring of (0x3000, 0x3000): magnitude * gain and 45 deg angle.
        e = '{x: 28617, y: 0, z: 8192, tx: 16, ty: 8, tz: 4, cyc: 0};
        start_op(1'b1, 16'h3000, 16'h3000, 0, 1'b1, e);
        settle();

`ifdef CORDIC_QUAD_CORR_EN
        // Rotation by +135 deg relies on the +90 deg pre-rotation.
        e = '{x: -11585, y: 11585, z: 0, tx: 8, ty: 8, tz: 32, cyc: 0};
        start_op(1'b0, 9949, 0, 16'h6000, 1'b1, e);
        settle();
`endif

        // Second start while iterating must be dropped.
        e = '{x: 11585, y: 11585, z: 0, tx: 8, ty: 8, tz: 32, cyc: 0};
        start_op(1'b0, 9949, 0, 16'h2000, 1'b1, e);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_mid_op", int'(busy), 1, 0);
        mode  = 1'b1;
        x_in  = 16'h3000;
        y_in  = 16'h3000;
        z_in  = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        settle();
        repeat (N_ITER + 3) @(posedge clk);
        #1;

        // Reset around iteration 7 aborts without a done pulse.
        start_op(1'b0, 1000, 2000, 100, 1'b0, e);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(ready), 1, 0);
        chk("abort_busy",  int'(busy),  0, 0);
        chk("abort_done",  int'(done),  0, 0);
        chk("abort_x_out", int'(x_out), 0, 0);
        chk("abort_y_out", int'(y_out), 0, 0);
        chk("abort_z_out", int'(z_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N_ITER + 6) @(posedge clk);
        #1;

        e = '{x: 11585, y: 11585, z: 0, tx: 8, ty: 8, tz: 32, cyc: 0};
        start_op(1'b0, 9949, 0, 16'h2000, 1'b1, e);
        settle();
        repeat (4) @(posedge clk);
        #1;

        chk("pending_results", sb.size(), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
